demux1to2_32bit_buf: RTL and testbench



---
 rtl/demux1to2_32bit_buf.sv | 92 +++++++++
 tb/tb_demux1to2_32bit_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_32bit_buf.sv
// Buffered 1-to-2 word demultiplexer: a valid/ready input is steered by ctrl into one
// of two first-word-fall-through FIFOs, and each FIFO drains through its own handshake.
module demux1to2_32bit_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] in_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic [CW-1:0]    occ1,
    output logic [CW-1:0]    occ2
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready_vec;
    logic [1:0]       out_valid_vec;
    logic [WIDTH-1:0] head      [2];
    logic [CW-1:0]    occ_vec   [2];

    assign out_ready_vec = {out2_ready, out1_ready};

    // Acceptance depends only on the pre-edge occupancy of the selected FIFO,
    // so a full FIFO never accepts a word even while it is being popped.
    assign in_ready = !reset && !(ctrl ? full[1] : full[0]);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]    wr_ptr_reg;
            logic [AW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    cnt_reg;

            assign full[gi]          = (cnt_reg == CW'(DEPTH));
            assign out_valid_vec[gi] = (cnt_reg != '0);
            assign push[gi]          = in_valid && in_ready && (ctrl == 1'(gi));
            assign pop[gi]           = out_valid_vec[gi] && out_ready_vec[gi];

            // Storage is never cleared; emptiness is tracked by the counter alone.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= in_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   cnt_reg <= cnt_reg + CW'(1);
                        2'b01:   cnt_reg <= cnt_reg - CW'(1);
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end

            // Head is forced to zero when empty so stale storage never leaks out.
            assign head[gi]    = out_valid_vec[gi] ? mem[rd_ptr_reg] : '0;
            assign occ_vec[gi] = cnt_reg;
        end
    endgenerate

    assign out1_valid = out_valid_vec[0];
    assign out2_valid = out_valid_vec[1];
    assign out1_data  = head[0];
    assign out2_data  = head[1];
    assign occ1       = occ_vec[0];
    assign occ2       = occ_vec[1];

endmodule

// File: tb/tb_demux1to2_32bit_buf.sv
// Self-checking bench for demux1to2_32bit_buf: directed steps drive the input, and a
// negedge monitor checks every output against per-destination scoreboard queues.
module tb_demux1to2_32bit_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             ctrl;
    logic [WIDTH-1:0] in_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;
    logic [CW-1:0]    occ1;
    logic [CW-1:0]    occ2;

    int total = 0;
    int bad   = 0;
    int pops1 = 0;
    int pops2 = 0;
    bit armed = 1'b0;
    bit toggle_en = 1'b0;
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] q2 [$];

    demux1to2_32bit_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ctrl       (ctrl),
        .in_data    (in_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .occ1       (occ1),
        .occ2       (occ2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model check on every falling edge, then advance the model by the handshakes
    // that the next rising edge will commit.
    always @(negedge clk) begin
        if (armed) begin
            logic             exp_ready;
            logic [WIDTH-1:0] h1;
            logic [WIDTH-1:0] h2;
            h1 = (q1.size() != 0) ? q1[0] : '0;
            h2 = (q2.size() != 0) ? q2[0] : '0;
            exp_ready = !reset && ((ctrl ? q2.size() : q1.size()) != DEPTH);
            chk("in_ready",   64'(in_ready),   64'(exp_ready));
            chk("occ1",       64'(occ1),       64'(q1.size()));
            chk("occ2",       64'(occ2),       64'(q2.size()));
            chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
            chk("out2_valid", 64'(out2_valid), 64'(q2.size() != 0));
            chk("out1_data",  64'(out1_data),  64'(h1));
            chk("out2_data",  64'(out2_data),  64'(h2));
            if (reset) begin
                q1.delete();
                q2.delete();
            end else begin
                if (q1.size() != 0 && out1_ready) begin
                    $display("pop  out1 data=%08h", h1);
                    void'(q1.pop_front());
                    pops1++;
                end
                if (q2.size() != 0 && out2_ready) begin
                    $display("pop  out2 data=%08h", h2);
                    void'(q2.pop_front());
                    pops2++;
                end
                if (in_valid && exp_ready) begin
                    $display("push ctrl=%0d data=%08h", ctrl, in_data);
                    if (ctrl) q2.push_back(in_data);
                    else      q1.push_back(in_data);
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (toggle_en) out1_ready = ~out1_ready;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic c);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        ctrl     = c;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_timeout", 64'(ok), 64'(1));
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        int p1_before;
        int p2_before;
        reset = 1'b1; in_valid = 1'b1; ctrl = 1'b0; in_data = 32'hDEAD_BEEF;
        out1_ready = 1'b0; out2_ready = 1'b0;

        // Reset held two cycles with in_valid asserted
        cyc();
        armed = 1'b1;
        cyc();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        reset = 1'b0; in_valid = 1'b0;
        cyc();
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_occ1", 64'(occ1), 64'(0));

        // Steering
        out1_ready = 1'b1; out2_ready = 1'b1;
        send(32'hA5A5_0001, 1'b0);
        chk("steer_out1", 64'(out1_data), 64'(32'hA5A5_0001));
        send(32'h5A5A_0002, 1'b1);
        chk("steer_out2", 64'(out2_data), 64'(32'h5A5A_0002));
        cyc(); cyc();
        chk("steer_pops", 64'(pops1 + pops2), 64'(2));

        // Fill FIFO1, third word blocked, redirect to FIFO2
        out1_ready = 1'b0;
        send(32'h0000_1111, 1'b0);
        send(32'h0000_2222, 1'b0);
        in_valid = 1'b1; ctrl = 1'b0; in_data = 32'h0000_3333;
        cyc(); cyc();
        chk("fill_occ1", 64'(occ1), 64'(2));
        chk("fill_blocked", 64'(in_ready), 64'(0));
        send(32'h0000_3333, 1'b1);
        cyc();

        // Full FIFO1 popped while a push is offered: push waits one cycle
        in_valid = 1'b1; ctrl = 1'b0; in_data = 32'h0000_4444; out1_ready = 1'b1;
        cyc();
        chk("fullpop_occ1", 64'(occ1), 64'(1));
        cyc();
        chk("fullpop_push_occ1", 64'(occ1), 64'(1));
        in_valid = 1'b0;
        repeat (3) cyc();

        // Wrap and ordering under toggling backpressure
        p1_before = pops1;
        toggle_en = 1'b1;
        for (int i = 1; i <= 10; i++) send(32'(i), 1'b0);
        toggle_en = 1'b0;
        out1_ready = 1'b1;
        repeat (4) cyc();
        chk("wrap_count", 64'(pops1 - p1_before), 64'(10));

        // Reset while both FIFOs hold data and handshakes are active
        out1_ready = 1'b0; out2_ready = 1'b0;
        send(32'hCAFE_0001, 1'b0);
        send(32'hCAFE_0002, 1'b0);
        send(32'hCAFE_0003, 1'b1);
        chk("pre_rst_occ1", 64'(occ1), 64'(2));
        chk("pre_rst_occ2", 64'(occ2), 64'(1));
        in_valid = 1'b1; ctrl = 1'b1; in_data = 32'hBAD0_BAD0;
        out1_ready = 1'b1; out2_ready = 1'b1; reset = 1'b1;
        cyc();
        chk("midrst_occ1", 64'(occ1), 64'(0));
        chk("midrst_occ2", 64'(occ2), 64'(0));
        chk("midrst_valid", 64'({out1_valid, out2_valid}), 64'(0));
        reset = 1'b0; in_valid = 1'b0;
        p1_before = pops1; p2_before = pops2;
        repeat (4) cyc();
        chk("midrst_no_emit", 64'((pops1 - p1_before) + (pops2 - p2_before)), 64'(0));
        chk("end_empty", 64'(q1.size() + q2.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
